// File: rtl/aes_decipher_block_par.sv
// Iterative AES inverse cipher (AES-128/192/256) with NUM_SBOX parallel 32-bit
// inverse S-box lanes; round keys are fetched combinationally by round index.

module aes_inv_sbox (
  input  logic [31:0] sword,
  output logic [31:0] new_sword
);
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry b sits at bit 2047-8*b, i.e. {~b, 3'b111}.
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign new_sword[8*i +: 8] = INV_SBOX[{~sword[8*i +: 8], 3'b111} -: 8];
  end
endmodule

module aes_decipher_block_par #(
  parameter int NUM_SBOX = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         abort,
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);
  localparam int SB_CYC = (NUM_SBOX > 0) ? 4 / NUM_SBOX : 1;
  localparam int CW     = (SB_CYC > 1) ? $clog2(SB_CYC) : 1;

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4)) begin : g_bad_param
    $error("aes_decipher_block_par: NUM_SBOX must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

  state_t                       fsm;
  logic [0:3][31:0]             st;
  logic [0:3][31:0]             sb_st;
  logic [CW-1:0]                sword_ctr;
  logic [3:0]                   nr;
  logic [NUM_SBOX-1:0][1:0]     lane_idx;
  logic [NUM_SBOX-1:0][31:0]    lane_in;
  logic [NUM_SBOX-1:0][31:0]    lane_out;

  assign new_block = st;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // s[3] is row 0 (most significant byte of the column word).
  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [3:0][7:0] s, m2, m4, m8, m9, mb, md, me;
    s = w;
    for (int i = 0; i < 4; i++) begin
      m2[i] = xt(s[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
      m9[i] = m8[i] ^ s[i];
      mb[i] = m8[i] ^ m2[i] ^ s[i];
      md[i] = m8[i] ^ m4[i] ^ s[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    return {me[3] ^ mb[2] ^ md[1] ^ m9[0],
            m9[3] ^ me[2] ^ mb[1] ^ md[0],
            md[3] ^ m9[2] ^ me[1] ^ mb[0],
            mb[3] ^ md[2] ^ m9[1] ^ me[0]};
  endfunction

  function automatic logic [0:3][31:0] inv_mix(input logic [0:3][31:0] s);
    logic [0:3][31:0] o;
    for (int c = 0; c < 4; c++) o[c] = inv_mixw(s[c]);
    return o;
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [0:3][31:0] inv_shift(input logic [0:3][31:0] s);
    logic [0:3][31:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][31-8*r -: 8] = s[2'(c - r)][31-8*r -: 8];
    return o;
  endfunction

  always_comb begin
    case (keylen)
      2'd0:    nr = 4'd10;
      2'd1:    nr = 4'd12;
      default: nr = 4'd14;
    endcase
  end

  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
    assign lane_idx[k] = 2'(int'(sword_ctr) * NUM_SBOX + k);
    assign lane_in[k]  = st[lane_idx[k]];
    aes_inv_sbox u_sbox (.sword(lane_in[k]), .new_sword(lane_out[k]));
  end

  always_comb begin
    sb_st = st;
    for (int k = 0; k < NUM_SBOX; k++) sb_st[lane_idx[k]] = lane_out[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= '0;
      round     <= '0;
      sword_ctr <= '0;
      ready     <= 1'b1;
      fsm       <= IDLE;
    end else if (abort && fsm != IDLE) begin
      // State words are left as they are; only control returns to idle.
      round     <= '0;
      sword_ctr <= '0;
      ready     <= 1'b1;
      fsm       <= IDLE;
    end else begin
      case (fsm)
        IDLE: if (next) begin
          round <= nr;
          ready <= 1'b0;
          fsm   <= INIT;
        end
        INIT: begin
          st        <= inv_shift(block ^ round_key);
          sword_ctr <= '0;
          fsm       <= SBOX;
        end
        SBOX: begin
          st <= sb_st;
          if (sword_ctr == CW'(SB_CYC - 1)) begin
            sword_ctr <= '0;
            round     <= round - 4'd1;
            fsm       <= MAIN;
          end else begin
            sword_ctr <= sword_ctr + 1'b1;
          end
        end
        MAIN: begin
          sword_ctr <= '0;
          if (round != 4'd0) begin
            st  <= inv_shift(inv_mix(st ^ round_key));
            fsm <= SBOX;
          end else begin
            st    <= st ^ round_key;
            ready <= 1'b1;
            fsm   <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decipher_block_par.sv
// Directed bench: FIPS-197 C.1-C.3 on three instances (NUM_SBOX = 1, 2, 4)
// sharing stimulus, with a key-schedule model serving round_key by round index.

module tb_aes_decipher_block_par;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  // PT ^ round key 0 of AES-128: the state just before the final AddRoundKey.
  localparam logic [127:0] PRE_ARK = 128'h00102030405060708090a0b0c0d0e0f0;

  logic         clk = 1'b0, reset_n = 1'b1, next = 1'b0, abort = 1'b0;
  logic [1:0]   keylen = 2'd0;
  logic [127:0] block = '0;
  logic [3:0]   round_1, round_2, round_4;
  logic [127:0] rk_1, rk_2, rk_4, nb_1, nb_2, nb_4;
  logic         rdy_1, rdy_2, rdy_4;
  logic [127:0] rk [16];
  int           n_vec = 0, n_err = 0;
  int           lat [3];
  int           rnd_bad;

  always #5 clk = ~clk;

  assign rk_1 = rk[round_1];
  assign rk_2 = rk[round_2];
  assign rk_4 = rk[round_4];

  aes_decipher_block_par #(.NUM_SBOX(1)) dut_1 (
    .clk(clk), .reset_n(reset_n), .next(next), .abort(abort), .keylen(keylen),
    .round(round_1), .round_key(rk_1), .block(block), .new_block(nb_1), .ready(rdy_1));
  aes_decipher_block_par #(.NUM_SBOX(2)) dut_2 (
    .clk(clk), .reset_n(reset_n), .next(next), .abort(abort), .keylen(keylen),
    .round(round_2), .round_key(rk_2), .block(block), .new_block(nb_2), .ready(rdy_2));
  aes_decipher_block_par #(.NUM_SBOX(4)) dut_4 (
    .clk(clk), .reset_n(reset_n), .next(next), .abort(abort), .keylen(keylen),
    .round(round_4), .round_key(rk_4), .block(block), .new_block(nb_4), .ready(rdy_4));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box from first principles: a^254 then the affine map.
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gm(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  task automatic load_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk[r] = '0;
  endtask

  // Expected round of the NUM_SBOX=1 instance t cycles after the start edge.
  function automatic int exp_rnd(input int nr, input int t);
    if (t == 0) return nr;
    return ((t - 1) % 5 < 4) ? nr - (t - 1) / 5 : nr - (t - 1) / 5 - 1;
  endfunction

  // Called at a negedge; returns at the first negedge with all instances ready.
  task automatic run_op(input logic [127:0] ct, input logic [1:0] kl, input int mid,
                        input int abort_at);
    int   t, nr;
    logic busy;
    nr     = (kl == 2'd0) ? 10 : (kl == 2'd1) ? 12 : 14;
    block  = ct;
    keylen = kl;
    next   = 1'b1;
    @(negedge clk);
    next    = 1'b0;
    lat     = '{0, 0, 0};
    rnd_bad = 0;
    t       = 0;
    busy    = 1'b1;
    while (busy && t < 400) begin
      if (!rdy_1) begin
        if (int'(round_1) != exp_rnd(nr, t)) rnd_bad++;
        lat[0]++;
      end
      if (!rdy_2) lat[1]++;
      if (!rdy_4) lat[2]++;
      busy = !(rdy_1 && rdy_2 && rdy_4);
      if (busy) begin
        next  = (t == mid);
        abort = (t == abort_at);
        if (t == mid) keylen = 2'd0;
        t++;
        @(negedge clk);
      end
    end
    next  = 1'b0;
    abort = 1'b0;
    chk("run_done", busy, 1'b0);
  endtask

  task automatic chk_run(input string tag, input int l1, input int l2, input int l4);
    chk({tag, "_pt1"}, nb_1, PT);
    chk({tag, "_pt2"}, nb_2, PT);
    chk({tag, "_pt4"}, nb_4, PT);
    chk({tag, "_lat1"}, lat[0], l1);
    chk({tag, "_lat2"}, lat[1], l2);
    chk({tag, "_lat4"}, lat[2], l4);
    chk({tag, "_rndseq"}, rnd_bad, 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {rdy_1, rdy_2, rdy_4, round_1, round_2, round_4}, {3'b111, 12'h000});
    chk("rst_nb1", nb_1, '0);
    chk("rst_nb2", nb_2, '0);
    chk("rst_nb4", nb_4, '0);
    reset_n = 1'b1;
    @(negedge clk);

    load_key(K128, 4);
    run_op(CT1, 2'd0, -1, -1);
    chk_run("c1", 51, 31, 21);

    load_key(K192, 6);
    run_op(CT2, 2'd1, -1, -1);
    chk_run("c2", 61, 37, 25);

    load_key(K256, 8);
    run_op(CT3, 2'd2, -1, -1);
    chk_run("c3", 71, 43, 29);

    // keylen=3 as AES-256, with a stray next (and keylen change) mid-run.
    run_op(CT3, 2'd3, 10, -1);
    chk_run("kl3_mid", 71, 43, 29);
    load_key(K128, 4);
    run_op(CT1, 2'd0, -1, -1);
    chk_run("b2b", 51, 31, 21);

    // Abort in SBOX of round 5 for the single-lane instance.
    run_op(CT1, 2'd0, -1, 27);
    chk("abt_sb_lat1", lat[0], 28);
    chk("abt_sb_lat2", lat[1], 28);
    chk("abt_sb_rnd", {round_1, round_2}, 8'h00);
    chk("abt_idle_nb4", nb_4, PT);

    // Abort in the final MAIN cycle: last AddRoundKey must not land.
    run_op(CT1, 2'd0, -1, 50);
    chk("abt_fin_lat1", lat[0], 51);
    chk("abt_fin_rnd", round_1, 4'd0);
    chk("abt_fin_nb1", nb_1, PRE_ARK);
    chk("abt_idle_nb2", nb_2, PT);
    repeat (3) @(negedge clk);
    chk("abt_fin_hold", nb_1, PRE_ARK);

    run_op(CT1, 2'd0, -1, -1);
    chk_run("post_abt", 51, 31, 21);

    // Asynchronous reset in the middle of an operation.
    block  = CT1;
    keylen = 2'd0;
    next   = 1'b1;
    @(negedge clk);
    next = 1'b0;
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rmid_ctl", {rdy_1, rdy_2, rdy_4, round_1, round_2, round_4}, {3'b111, 12'h000});
    chk("rmid_nb1", nb_1, '0);
    chk("rmid_nb2", nb_2, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(CT1, 2'd0, -1, -1);
    chk_run("post_rst", 51, 31, 21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
